// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter with bounded lock sharing one single-port RAM
module ram_arbiter #(
  parameter int NReq      = 2,
  parameter int DataWidth = 32,
  parameter int NPos      = 1024,
  parameter int NPosWidth = $clog2(NPos),
  parameter int MaxLock   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NReq-1:0]           req_i,
  input  logic [NReq-1:0]           we_i,
  input  logic [NReq-1:0]           lock_i,
  input  logic [NReq*NPosWidth-1:0] addr_i,
  input  logic [NReq*DataWidth-1:0] wdata_i,
  output logic [NReq-1:0]           gnt_o,
  output logic [NReq-1:0]           rvalid_o,
  output logic [DataWidth-1:0]      rdata_o,
  output logic [NPosWidth-1:0]      ram_a_o,
  output logic                      ram_we_o,
  output logic [DataWidth-1:0]      ram_wd_o,
  input  logic [DataWidth-1:0]      ram_rd_i
);

  localparam int IdxW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int CntW = $clog2(MaxLock + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxLock);
  localparam logic [IdxW-1:0] LastRst = IdxW'(NReq - 1);

  typedef enum logic {
    FREE,
    LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      last_q;
  logic [IdxW-1:0]      lock_owner_q, lock_owner_d;
  logic [CntW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [CntW-1:0]      lock_cnt_inc;
  logic [NReq-1:0]      rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q;

  logic                 rr_found;
  logic [IdxW-1:0]      rr_idx;
  logic [IdxW-1:0]      rr_cand;
  logic                 gnt_any;
  logic [IdxW-1:0]      gnt_idx;
  logic [NReq-1:0]      gnt;

  assign lock_cnt_inc = lock_cnt_q + CntW'(1);

  // Round-robin pick: first requester scanning upward from the one after last_q.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= NReq; i++) begin
      rr_cand = IdxW'((int'(last_q) + i) % NReq);
      if (!rr_found && req_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Arbitration FSM: a locked owner wins while it requests; otherwise fall back to round-robin.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    gnt_any      = 1'b0;
    gnt_idx      = '0;
    if (state_q == LOCKED && req_i[lock_owner_q]) begin
      gnt_any    = 1'b1;
      gnt_idx    = lock_owner_q;
      lock_cnt_d = lock_cnt_inc;
      if (!lock_i[lock_owner_q] || lock_cnt_inc == CntMax) begin
        state_d    = FREE;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = FREE;
      lock_cnt_d = '0;
      if (rr_found) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
        if (lock_i[rr_idx] && (MaxLock > 1)) begin
          state_d      = LOCKED;
          lock_owner_d = rr_idx;
          lock_cnt_d   = CntW'(1);
        end
      end
    end
  end

  // One-hot grant, forced low while reset is asserted.
  always_comb begin
    gnt = '0;
    for (int k = 0; k < NReq; k++) begin
      gnt[k] = rst_ni && gnt_any && (gnt_idx == IdxW'(k));
    end
  end

  // RAM port mux: granted requester's slice, all zero when idle.
  always_comb begin
    ram_a_o  = '0;
    ram_we_o = 1'b0;
    ram_wd_o = '0;
    for (int k = 0; k < NReq; k++) begin
      if (gnt[k]) begin
        ram_a_o  = addr_i[k*NPosWidth +: NPosWidth];
        ram_we_o = we_i[k];
        ram_wd_o = wdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign rvalid_d = gnt & ~we_i;

  // State, priority pointer, lock bookkeeping and the registered read response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FREE;
      last_q       <= LastRst;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid_q     <= rvalid_d;
      if (gnt_any) begin
        last_q <= gnt_idx;
      end
      if (|rvalid_d) begin
        rdata_q <= ram_rd_i;
      end
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule
